key_scan_ctrl: RTL and testbench
================================

// Module: key_scan_ctrl
// PURPOSE
//  4x4 matrix keypad scanner and debouncer. Drives row select/enable toward the
//  row DEMUX, samples the 4 column lines and emits a debounced 4-bit key code with
//  a one-cycle valid strobe. key_code/key_valid feed the 4-to-16 Decoder (IN/EN).
// PARAMETERS
//  DWELL_CYCLES    4  clock cycles each row is driven (>=2); one scan = 4*DWELL_CYCLES
//  DEBOUNCE_SCANS  3  consecutive identical full-scan results needed to accept press/release (>=1)
// PORTS
//  clk        in   1  single clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  scan_en    in   1  1 = scanning enabled; 0 = idle
//  col        in   4  column lines, active-high, already synchronised, bit i = column i
//  row_sel    out  2  row currently driven (to DEMUX S)
//  row_en     out  1  row drive enable (to DEMUX IN)
//  key_code   out  4  {row[1:0], col_idx[1:0]} of last accepted key
//  key_valid  out  1  one-cycle strobe: new key accepted
//  key_held   out  1  accepted key still down (not yet debounced-released)
//  multi_key  out  1  last completed scan saw >1 pressed key
// BEHAVIOUR
//  - Reset: row_sel=0, row_en=0, key_code=0, key_valid=0, key_held=0, multi_key=0, state IDLE, counters 0.
//  - All outputs registered. row_en=1 in every state except IDLE.
//  - Dwell counter runs 0..DWELL_CYCLES-1 per row; col sampled when count=DWELL_CYCLES-1;
//    row_sel increments (3 wraps to 0) in the following cycle. Scan ends on the row-3 sample.
//  - Per-row sample: lowest set col bit gives col_idx; >1 bit set marks the scan multi.
//  - Scan result: NONE (no bits over 4 rows), SINGLE(code), MULTI (>1 key anywhere).
//    multi_key updated at each scan end (1 iff MULTI); MULTI never accepted as a key.
//  - FSM (transitions evaluated at scan end unless stated):
//    IDLE:     scan_en=1 -> SCAN, dwell and row counters start at 0 next cycle.
//    SCAN:     SINGLE(c) -> DEBOUNCE, cand=c, cnt=1; else stay.
//              If DEBOUNCE_SCANS=1, SINGLE(c) goes directly to PRESSED with strobe.
//    DEBOUNCE: SINGLE(cand) -> cnt+1; cnt reaching DEBOUNCE_SCANS -> PRESSED,
//              key_code<=cand, key_valid=1 for exactly the next cycle; else (NONE/MULTI/other) -> SCAN.
//    PRESSED:  key_held=1. NONE -> rel_cnt+1; any other result -> rel_cnt=0;
//              rel_cnt reaching DEBOUNCE_SCANS -> SCAN, key_held=0. No second strobe while held.
//  - Latency: key stable from scan start -> key_valid in the cycle after the DEBOUNCE_SCANS-th scan end.
//  - key_code holds its value after release until the next accepted key.
//  - scan_en=0 in any state: next cycle IDLE, row_en=0, row_sel=0, key_held=0, counters cleared,
//    no key_valid; key_code and multi_key retained. An in-progress debounce is discarded.
//  - rst overrides scan_en and all state in the same edge.
// STRUCTURE
//  - Shared package key_scan_pkg: state enum {IDLE,SCAN,DEBOUNCE,PRESSED};
//    scan-result enum {RES_NONE,RES_SINGLE,RES_MULTI}; KEY_W=4, ROW_W=2.
//  - One sub-module: col_prio_enc (combinational: col[3:0] -> idx[1:0], any, multi).
//  - Top: dwell counter, row counter, per-scan accumulator, debounce/release counters, FSM.
// TESTING (DWELL_CYCLES=4, DEBOUNCE_SCANS=3; cycle 1 = first SCAN cycle)
//  1 Reset while scanning with key down -> all outputs 0 next cycle, state IDLE, no strobe.
//  2 Key row2/col1 held from cycle 1 -> key_valid=1 only in cycle 49, key_code=4'b1001,
//    key_held=1 from cycle 49; row_sel steps 0,1,2,3 every 4 cycles.
//  3 Release after acceptance -> key_held falls one cycle after the 3rd all-NONE scan end; no strobe.
//  4 Keys row0/col0 and row3/col3 both down -> multi_key=1 after cycle 16, no key_valid ever.
//  5 Bounce: key present 2 scans, absent 1, present 3 -> exactly one strobe, after 6th scan end.
//  6 scan_en dropped mid-DEBOUNCE -> row_en=0 next cycle, no strobe; re-enable restarts count from scan 1.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared types and widths for the 4x4 keypad scanner.
// Key codes are {row, column index}.
package key_scan_pkg;

  localparam int ROW_W   = 2;
  localparam int COL_W   = 2;
  localparam int KEY_W   = ROW_W + COL_W;
  localparam int NUM_COL = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DEBOUNCE,
    PRESSED
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } scan_res_t;

  // Running summary of the rows already sampled in the current scan.
  typedef struct packed {
    logic             found;
    logic             multi;
    logic [KEY_W-1:0] code;
  } scan_acc_t;

  function automatic logic [KEY_W-1:0] make_code(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] idx);
    return {row, idx};
  endfunction

endpackage

// File: rtl/col_prio_enc.sv
// Column priority encoder: the lowest set column wins,
// and more than one set column is flagged as multi.
module col_prio_enc
  import key_scan_pkg::*;
(
  input  logic [NUM_COL-1:0] col,
  output logic [COL_W-1:0]   idx,
  output logic               any,
  output logic               multi
);

  always_comb begin
    idx = '0;
    if (col[0])      idx = 2'd0;
    else if (col[1]) idx = 2'd1;
    else if (col[2]) idx = 2'd2;
    else if (col[3]) idx = 2'd3;
    any   = |col;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    multi = (col & (col - 4'd1)) != '0;
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner: steps through the rows, classifies each full scan,
// and debounces presses and releases over whole scans.
module key_scan_ctrl
  import key_scan_pkg::*;
#(
  parameter int DWELL_CYCLES   = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_en,
  input  logic [NUM_COL-1:0] col,
  output logic [ROW_W-1:0]   row_sel,
  output logic               row_en,
  output logic [KEY_W-1:0]   key_code,
  output logic               key_valid,
  output logic               key_held,
  output logic               multi_key
);

  localparam int DWW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int CNW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_CYCLES - 1);
  localparam logic [CNW-1:0] DEB_TARGET = CNW'(DEBOUNCE_SCANS);

  state_t           state, next_state;
  logic [DWW-1:0]   dwell;
  logic [ROW_W-1:0] row;
  scan_acc_t        acc;
  logic [KEY_W-1:0] cand;
  logic [CNW-1:0]   deb_cnt, rel_cnt;

  logic [COL_W-1:0] enc_idx;
  logic             enc_any, enc_multi;

  logic             sample, scan_end;
  logic             cur_found, cur_multi;
  logic [KEY_W-1:0] cur_code;
  scan_res_t        res;
  logic             cand_match, deb_done, rel_done;
  logic [CNW-1:0]   deb_next, rel_next;

  logic             accept;
  logic             row_en_d, key_valid_d, key_held_d, multi_key_d;
  logic [KEY_W-1:0] key_code_d;

  col_prio_enc u_enc (
    .col   (col),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  assign sample   = (state != IDLE) && (dwell == DWELL_LAST);
  assign scan_end = sample && (row == {ROW_W{1'b1}});
  assign row_sel  = row;

  // Fold the current row sample into the scan summary so the row-3 sample
  // completes the result in the same cycle it is taken.
  always_comb begin
    cur_found = acc.found | enc_any;
    cur_multi = acc.multi | enc_multi | (acc.found & enc_any);
    cur_code  = acc.found ? acc.code : make_code(row, enc_idx);
    if (cur_multi)      res = RES_MULTI;
    else if (cur_found) res = RES_SINGLE;
    else                res = RES_NONE;
    cand_match = (res == RES_SINGLE) && (cur_code == cand);
    deb_next   = deb_cnt + CNW'(1);
    rel_next   = rel_cnt + CNW'(1);
    deb_done   = (deb_next == DEB_TARGET);
    rel_done   = (rel_next == DEB_TARGET);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!scan_en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: next_state = SCAN;
        SCAN: begin
          if (scan_end && res == RES_SINGLE)
            next_state = (DEBOUNCE_SCANS == 1) ? PRESSED : DEBOUNCE;
        end
        DEBOUNCE: begin
          if (scan_end) begin
            if (cand_match && deb_done) next_state = PRESSED;
            else if (!cand_match)       next_state = SCAN;
          end
        end
        PRESSED: begin
          if (scan_end && res == RES_NONE && rel_done) next_state = SCAN;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // A key is accepted only on the scan end that completes the debounce run.
  always_comb begin
    accept = 1'b0;
    if (scan_en && scan_end) begin
      if (state == SCAN && res == RES_SINGLE && DEBOUNCE_SCANS == 1) accept = 1'b1;
      if (state == DEBOUNCE && cand_match && deb_done)               accept = 1'b1;
    end
    key_valid_d = accept;
    key_code_d  = key_code;
    if (accept) key_code_d = (state == SCAN) ? cur_code : cand;
    key_held_d  = (next_state == PRESSED);
    row_en_d    = (next_state != IDLE);
    multi_key_d = (scan_en && scan_end) ? (res == RES_MULTI) : multi_key;
  end

  always_ff @(posedge clk) begin
    if (rst || !scan_en || state == IDLE) begin
      dwell   <= '0;
      row     <= '0;
      acc     <= '0;
      cand    <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
    end else begin
      if (sample) begin
        dwell <= '0;
        row   <= row + ROW_W'(1);
        if (scan_end) begin
          acc <= '0;
        end else begin
          acc.found <= cur_found;
          acc.multi <= cur_multi;
          acc.code  <= cur_code;
        end
      end else begin
        dwell <= dwell + DWW'(1);
      end
      if (scan_end) begin
        case (state)
          SCAN: begin
            if (res == RES_SINGLE) begin
              cand    <= cur_code;
              deb_cnt <= CNW'(1);
              rel_cnt <= '0;
            end
          end
          DEBOUNCE: begin
            deb_cnt <= (cand_match && !deb_done) ? deb_next : '0;
            rel_cnt <= '0;
          end
          PRESSED: rel_cnt <= (res == RES_NONE && !rel_done) ? rel_next : '0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_en    <= 1'b0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      row_en    <= row_en_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      key_held  <= key_held_d;
      multi_key <= multi_key_d;
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: a keypad matrix drives the columns from row_sel,
// and a scan-level reference model predicts the key outputs.
module tb_key_scan_ctrl;

  localparam int DWELL = 4;
  localparam int DS    = 3;
  localparam int SCANC = 4 * DWELL;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic [3:0] col;
  logic [1:0] row_sel;
  logic       row_en;
  logic [3:0] key_code;
  logic       key_valid, key_held, multi_key;

  logic [15:0] key_mat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;

  logic [3:0] exp_code;
  logic       exp_multi;
  logic       m_held, m_pend;
  logic [3:0] m_cand;
  int         m_run, m_rel;

  key_scan_ctrl #(.DWELL_CYCLES(DWELL), .DEBOUNCE_SCANS(DS)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .col       (col),
    .row_sel   (row_sel),
    .row_en    (row_en),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  always #5 clk = ~clk;

  // Bit row*4+col of key_mat is the key at that position.
  assign col = row_en ? key_mat[{row_sel, 2'b00} +: 4] : 4'd0;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic model_clear();
    m_held = 1'b0; m_pend = 1'b0; m_run = 0; m_rel = 0; m_cand = 4'd0;
  endtask

  // Whole-scan rules: count pressed keys and apply press/release debouncing.
  task automatic model_scan_end(input logic [15:0] keys);
    int n;
    logic [3:0] code;
    n = $countones(keys);
    code = 4'd0;
    for (int i = 0; i < 16; i++) if (keys[i]) code = 4'(i);
    exp_multi = (n > 1);
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0) begin
          if (code == m_cand) m_run++;
          else m_run = 0;
        end else begin
          m_cand = code;
          m_run = 1;
        end
        if (m_run == DS) begin
          m_held = 1'b1; m_rel = 0; m_run = 0; exp_code = m_cand; m_pend = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) m_rel++;
      else m_rel = 0;
      if (m_rel == DS) begin
        m_held = 1'b0; m_rel = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; scan_en = 1'b0; key_mat = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_code = 4'd0; exp_multi = 1'b0;
    model_clear();
  endtask

  task automatic enable_scan();
    @(negedge clk);
    scan_en = 1'b1;
    cyc = 0;
  endtask

  task automatic go_idle();
    scan_en = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  // Drives one scan (or its first ncyc cycles) and compares every cycle to the model.
  task automatic drive_scan(input logic [15:0] keys, input int ncyc);
    logic [1:0] exp_row;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cyc++;
      if (c == 0) key_mat = keys;
      exp_row = 2'(c / DWELL);
      checks++;
      if (row_sel !== exp_row) begin
        errors++; $display("[TB] FAIL row_sel cyc=%0d got=%0d exp=%0d", cyc, row_sel, exp_row);
      end
      checks++;
      if (row_en !== 1'b1) begin
        errors++; $display("[TB] FAIL row_en cyc=%0d got=%b exp=1", cyc, row_en);
      end
      checks++;
      if (key_valid !== (c == 0 && m_pend)) begin
        errors++; $display("[TB] FAIL key_valid cyc=%0d got=%b exp=%b", cyc, key_valid, (c == 0 && m_pend));
      end
      checks++;
      if (key_held !== m_held) begin
        errors++; $display("[TB] FAIL key_held cyc=%0d got=%b exp=%b", cyc, key_held, m_held);
      end
      checks++;
      if (key_code !== exp_code) begin
        errors++; $display("[TB] FAIL key_code cyc=%0d got=%h exp=%h", cyc, key_code, exp_code);
      end
      checks++;
      if (multi_key !== exp_multi) begin
        errors++; $display("[TB] FAIL multi_key cyc=%0d got=%b exp=%b", cyc, multi_key, exp_multi);
      end
      if (key_valid === 1'b1) begin
        strobe_cnt++; strobe_cyc = cyc;
      end
      if (c == 0) m_pend = 1'b0;
      if (c == SCANC - 1) model_scan_end(keys);
    end
  endtask

  task automatic test_reset();
    logic [15:0] k;
    $display("[TB] test_reset");
    do_reset();
    k = 16'h0200;
    enable_scan();
    drive_scan(k, SCANC);
    drive_scan(k, SCANC);
    drive_scan(k, 5);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({row_sel, row_en, key_code, key_valid, key_held, multi_key} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b exp=0",
               {row_sel, row_en, key_code, key_valid, key_held, multi_key});
    end
    rst = 1'b0; scan_en = 1'b0;
    exp_code = 4'd0; exp_multi = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (row_en !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle row_en=%b key_valid=%b exp=0,0", row_en, key_valid);
    end
  endtask

  task automatic test_press_release();
    logic [15:0] k;
    $display("[TB] test_press_release");
    do_reset();
    k = 16'h0200;
    strobe_cnt = 0; strobe_cyc = 0;
    enable_scan();
    repeat (5) drive_scan(k, SCANC);
    checks++;
    if (strobe_cnt !== 1 || strobe_cyc !== 49) begin
      errors++; $display("[TB] FAIL press_strobe count=%0d cyc=%0d exp=1,49", strobe_cnt, strobe_cyc);
    end
    checks++;
    if (key_code !== 4'b1001 || key_held !== 1'b1) begin
      errors++; $display("[TB] FAIL press_code code=%b held=%b exp=1001,1", key_code, key_held);
    end
    strobe_cnt = 0;
    repeat (2) drive_scan(16'h0, SCANC);
    checks++;
    if (key_held !== 1'b1) begin
      errors++; $display("[TB] FAIL release_early held=%b exp=1", key_held);
    end
    drive_scan(16'h0, SCANC);
    drive_scan(16'h0, 1);
    checks++;
    if (key_held !== 1'b0 || key_code !== 4'b1001 || strobe_cnt !== 0) begin
      errors++; $display("[TB] FAIL release held=%b code=%b strobes=%0d exp=0,1001,0",
                         key_held, key_code, strobe_cnt);
    end
  endtask

  task automatic test_multi();
    $display("[TB] test_multi");
    do_reset();
    strobe_cnt = 0;
    enable_scan();
    repeat (4) drive_scan(16'h8001, SCANC);
    checks++;
    if (multi_key !== 1'b1 || strobe_cnt !== 0) begin
      errors++; $display("[TB] FAIL multi multi_key=%b strobes=%0d exp=1,0", multi_key, strobe_cnt);
    end
  endtask

  task automatic test_bounce();
    logic [15:0] k;
    $display("[TB] test_bounce");
    do_reset();
    k = 16'h0040;
    strobe_cnt = 0; strobe_cyc = 0;
    enable_scan();
    drive_scan(k, SCANC);
    drive_scan(k, SCANC);
    drive_scan(16'h0, SCANC);
    repeat (4) drive_scan(k, SCANC);
    checks++;
    if (strobe_cnt !== 1 || strobe_cyc !== 6 * SCANC + 1) begin
      errors++; $display("[TB] FAIL bounce count=%0d cyc=%0d exp=1,%0d", strobe_cnt, strobe_cyc, 6 * SCANC + 1);
    end
  endtask

  task automatic test_disable();
    logic [15:0] k;
    $display("[TB] test_disable");
    do_reset();
    k = 16'h0004;
    strobe_cnt = 0; strobe_cyc = 0;
    enable_scan();
    drive_scan(k, SCANC);
    drive_scan(k, SCANC);
    drive_scan(k, 6);
    scan_en = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (row_en !== 1'b0 || row_sel !== 2'd0 || key_held !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL disable row_en=%b row_sel=%0d held=%b valid=%b exp=0,0,0,0",
                         row_en, row_sel, key_held, key_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b0 || row_en !== 1'b0) begin
        errors++; $display("[TB] FAIL disable_idle valid=%b row_en=%b exp=0,0", key_valid, row_en);
      end
    end
    enable_scan();
    drive_scan(k, SCANC);
    drive_scan(k, SCANC);
    checks++;
    if (strobe_cnt !== 0) begin
      errors++; $display("[TB] FAIL restart_early strobes=%0d exp=0", strobe_cnt);
    end
    drive_scan(k, SCANC);
    drive_scan(k, 1);
    checks++;
    if (strobe_cnt !== 1 || strobe_cyc !== 49 || key_code !== 4'd2) begin
      errors++; $display("[TB] FAIL restart count=%0d cyc=%0d code=%h exp=1,49,2",
                         strobe_cnt, strobe_cyc, key_code);
    end
  endtask

  task automatic test_random();
    logic [15:0] k;
    int r, b1, b2;
    $display("[TB] test_random");
    do_reset();
    k = 16'h0;
    enable_scan();
    for (int s = 0; s < 80; s++) begin
      r = $urandom_range(0, 9);
      if (r >= 5 && r <= 6) begin
        k = 16'h1 << $urandom_range(0, 15);
      end else if (r >= 7 && r <= 8) begin
        k = 16'h0;
      end else if (r == 9) begin
        b1 = $urandom_range(0, 15);
        b2 = (b1 + $urandom_range(1, 15)) % 16;
        k = (16'h1 << b1) | (16'h1 << b2);
      end
      if ($urandom_range(0, 19) == 0) begin
        drive_scan(k, $urandom_range(1, SCANC - 1));
        go_idle();
        enable_scan();
      end else begin
        drive_scan(k, SCANC);
      end
    end
  endtask

  initial begin
    rst = 1'b1; scan_en = 1'b0; key_mat = '0;
    exp_code = 4'd0; exp_multi = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if ({row_sel, row_en, key_code, key_valid, key_held, multi_key} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL power_on_reset got=%b exp=0",
               {row_sel, row_en, key_code, key_valid, key_held, multi_key});
    end
    test_reset();
    test_press_release();
    test_multi();
    test_bounce();
    test_disable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
